bus_xfer_seq: RTL and testbench
===============================

# bus_xfer_seq

Parametrised bus-transfer sequencer that replaces hand-driven load/select control lines with a timed, relay-style transfer cycle. It accepts a transfer request (one source, any set of destinations), then drives the source select strobe, waits a settle interval, pulses the destination load strobes, and releases the bus break-before-make. It sits between the instruction decoder and the register/memory blocks, driving their `sel*`/`ld*` inputs over the control bus.

## Interface
- `NUM_SRC`, 14: number of bus drivers (select strobes); ≥ 2.
- `NUM_DST`, 17: number of bus loaders (load strobes); ≥ 1.
- `SETTLE_CYCLES`, 2: cycles with select asserted before load; ≥ 1.
- `HOLD_CYCLES`, 1: cycles the load strobes are asserted; ≥ 1.
- `SW` = `$clog2(NUM_SRC)`, derived local parameter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: transfer request.
- `req_ready`  out  1: sequencer can accept; a transfer is taken when `req_valid && req_ready`.
- `req_src`  in  SW: source index.
- `req_dst`  in  NUM_DST: destination mask; multiple bits allowed.
- `ext_drive`  in  1: some other agent is driving the bus (contention input).
- `sel`  out  NUM_SRC: one-hot source select, or all zero.
- `ld`  out  NUM_DST: destination load strobes.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse on successful completion.
- `err`  out  1: one-cycle pulse on a rejected or aborted transfer.

## Operation
- States: IDLE, SELECT, LOAD, RELEASE, ERR. The accepted `req_src`/`req_dst` are registered at acceptance and held until the transfer finishes.
- IDLE: `req_ready`=1 and all strobes 0. On acceptance, a valid request goes to SELECT. An invalid request (`req_src` ≥ NUM_SRC or `req_dst`==0) goes to ERR.
- SELECT: `sel[src]`=1, `ld`=0. The settle counter runs from SETTLE_CYCLES-1 down to 0, then the FSM goes to LOAD.
- LOAD: `sel[src]` stays 1 and `ld`=registered mask. The hold counter runs from HOLD_CYCLES-1 down to 0, then the FSM goes to RELEASE.
- RELEASE: `sel`=0, `ld`=0, `done`=1, then IDLE. `ld` always drops no later than `sel` (break-before-make).
- ERR: all strobes 0, `err`=1 for one cycle, then IDLE.
- `sel` is never multi-hot. `ld` is asserted only while `sel` is asserted.
- Counter width is `$clog2(max(SETTLE_CYCLES,HOLD_CYCLES)+1)`. One shared counter is acceptable. The counter reloads on every state entry.
- `req_valid` while `req_ready`=0 is ignored; the requester holds the request.

## Timing
- Reset: state is IDLE, counter is 0, `sel`=0, `ld`=0, `busy`=0, `done`=0, `err`=0, `req_ready`=1. All outputs are registered. Reset asserted mid-transfer drops every strobe immediately (asynchronously), and any pending `done` is lost.
- Acceptance edge is cycle 0. SELECT covers cycles 1..S, LOAD covers S+1..S+H, RELEASE (`done`) is cycle S+H+1, and IDLE/`req_ready` returns at S+H+2. Here S = SETTLE_CYCLES and H = HOLD_CYCLES.
- Throughput: one transfer per S+H+2 cycles. Back-to-back requests see `req_ready` low from cycle 1 through S+H+1.
- Invalid request: `err` in cycle 1, `req_ready` back in cycle 2.
- `done` and `err` are never high in the same cycle.

## Configuration
- `BUS_XFER_CONTENTION_CHK_EN` defined:
  - `ext_drive` sampled high in SELECT or LOAD aborts the transfer.
  - The next cycle is ERR: all strobes 0 and `err`=1. No `done` is issued, and IDLE follows.
  - `ext_drive` high at acceptance counts as an invalid request.
- Not defined: the `ext_drive` port exists but is ignored, and the sequencer never aborts.

## Test plan
- Reset then idle (defaults S=2, H=1): all outputs 0 except `req_ready`=1.
- Valid transfer `req_src`=3, `req_dst`=0x00005 at edge 0:
  - `sel`=0x0008 in cycles 1–3.
  - `ld`=0x00005 in cycle 3 only.
  - `done` in cycle 4 with `sel`=0.
  - `req_ready`=1 in cycle 5.
- Back-to-back: `req_valid` held high with two requests → the second is accepted at cycle 5 and its `done` arrives in cycle 9. No cycle has `sel` multi-hot or `ld` without `sel`.
- Invalid requests:
  - `req_src`=14 → `err` in cycle 1, no strobes, `req_ready` in cycle 2.
  - `req_dst`=0 gives the same response.
- Reset asserted in LOAD (cycle 3) → `sel` and `ld` fall to 0 without a clock. After release: IDLE, no `done`.
- With `BUS_XFER_CONTENTION_CHK_EN`: `ext_drive`=1 in cycle 2 → `err` in cycle 3, `ld` never asserted, no `done`. Without the macro, the same stimulus completes normally with `done` in cycle 4.

Source files
------------

// File: rtl/bus_xfer_seq.sv
// Relay-style bus transfer sequencer: select source, settle, pulse loads, release.
// Optional BUS_XFER_CONTENTION_CHK_EN aborts a transfer when ext_drive is seen.
module bus_xfer_seq #(
  parameter int unsigned NUM_SRC       = 14,
  parameter int unsigned NUM_DST       = 17,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1,
  localparam int unsigned SW           = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SW-1:0]      req_src,
  input  logic [NUM_DST-1:0] req_dst,
  input  logic               ext_drive,
  output logic [NUM_SRC-1:0] sel,
  output logic [NUM_DST-1:0] ld,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned CMAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

`ifdef BUS_XFER_CONTENTION_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    LOAD    = 3'd2,
    RELEASE = 3'd3,
    ERR     = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        src_q, src_d;
  logic [NUM_DST-1:0]   dst_q, dst_d;
  logic [NUM_SRC-1:0]   sel_q, sel_d;
  logic [NUM_DST-1:0]   ld_q, ld_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;
  logic                 contention;
  logic                 bad_req;

  assign contention = CHK_EN & ext_drive;
  assign bad_req    = (32'(req_src) >= 32'(NUM_SRC)) || (req_dst == '0) || contention;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          src_d = req_src;
          dst_d = req_dst;
          if (bad_req) begin
            state_d = ERR;
            cnt_d   = '0;
          end else begin
            state_d = SELECT;
            cnt_d   = CW'(SETTLE_CYCLES - 1);
          end
        end
      end
      SELECT: begin
        if (contention) begin
          state_d = ERR;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = LOAD;
          cnt_d   = CW'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOAD: begin
        if (contention) begin
          state_d = ERR;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      ERR: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // without adding a cycle of latency to the strobes.
  always_comb begin
    sel_d   = '0;
    ld_d    = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    if (state_d == SELECT || state_d == LOAD) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        sel_d[i] = (src_d == SW'(i));
      end
    end
    if (state_d == LOAD)    ld_d   = dst_d;
    if (state_d == RELEASE) done_d = 1'b1;
    if (state_d == ERR)     err_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      sel_q   <= '0;
      ld_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      sel_q   <= sel_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign sel       = sel_q;
  assign ld        = ld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign req_ready = ready_q;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed self-checking bench for bus_xfer_seq (defaults S=2, H=1).
// Contention expectations follow BUS_XFER_CONTENTION_CHK_EN.
module tb_bus_xfer_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_src = '0;
  logic [16:0] req_dst = '0;
  logic        ext_drive = 1'b0;
  logic [13:0] sel;
  logic [16:0] ld;
  logic        busy, done, err;

  int n_checks = 0;
  int n_pass   = 0;
  int inv_bad  = 0;

  bus_xfer_seq #(
    .NUM_SRC(14), .NUM_DST(17), .SETTLE_CYCLES(2), .HOLD_CYCLES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .ext_drive(ext_drive),
    .sel(sel), .ld(ld), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Structural invariants watched on every falling edge.
  always @(negedge clk) begin
    if ($countones(sel) > 1 || ((|ld) && !(|sel)) || (done && err))
      inv_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [13:0] e_sel, input logic [16:0] e_ld,
                         input logic e_done, input logic e_err, input logic e_ready);
    chk({tag, ".sel"},   32'(sel),       32'(e_sel));
    chk({tag, ".ld"},    32'(ld),        32'(e_ld));
    chk({tag, ".done"},  32'(done),      32'(e_done));
    chk({tag, ".err"},   32'(err),       32'(e_err));
    chk({tag, ".ready"}, 32'(req_ready), 32'(e_ready));
    chk({tag, ".busy"},  32'(busy),      32'(!e_ready));
  endtask

  // Full single transfer: request in cycle 0, checks in cycles 1..5.
  task automatic xfer(input string tag, input logic [3:0] src, input logic [16:0] dst,
                      input logic [13:0] e_sel);
    req_valid = 1'b1; req_src = src; req_dst = dst;
    step(); req_valid = 1'b0;
    chk_out({tag, ".c1"}, e_sel, '0, 1'b0, 1'b0, 1'b0);
    step(); chk_out({tag, ".c2"}, e_sel, '0, 1'b0, 1'b0, 1'b0);
    step(); chk_out({tag, ".c3"}, e_sel, dst, 1'b0, 1'b0, 1'b0);
    step(); chk_out({tag, ".c4"}, '0, '0, 1'b1, 1'b0, 1'b0);
    step(); chk_out({tag, ".c5"}, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic bad_req(input string tag, input logic [3:0] src, input logic [16:0] dst);
    req_valid = 1'b1; req_src = src; req_dst = dst;
    step(); req_valid = 1'b0;
    chk_out({tag, ".c1"}, '0, '0, 1'b0, 1'b1, 1'b0);
    step(); chk_out({tag, ".c2"}, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    #12;
    chk_out("reset", '0, '0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    step(); step();
    chk_out("idle", '0, '0, 1'b0, 1'b0, 1'b1);

    xfer("xfer3", 4'd3, 17'h00005, 14'h0008);
    xfer("xfer0", 4'd0, 17'h1FFFF, 14'h0001);
    xfer("xfer13", 4'd13, 17'h10000, 14'h2000);

    // Back-to-back with req_valid held: second accepted at edge 5, done in cycle 9
    req_valid = 1'b1; req_src = 4'd3; req_dst = 17'h00005;
    step(); req_src = 4'd7; req_dst = 17'h10000;
    chk_out("b2b.c1", 14'h0008, '0, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk_out("b2b.c3", 14'h0008, 17'h00005, 1'b0, 1'b0, 1'b0);
    step(); chk_out("b2b.c4", '0, '0, 1'b1, 1'b0, 1'b0);
    step(); chk_out("b2b.c5", '0, '0, 1'b0, 1'b0, 1'b1);
    step(); req_valid = 1'b0;
    chk_out("b2b.c6", 14'h0080, '0, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk_out("b2b.c8", 14'h0080, 17'h10000, 1'b0, 1'b0, 1'b0);
    step(); chk_out("b2b.c9", '0, '0, 1'b1, 1'b0, 1'b0);
    step(); chk_out("b2b.c10", '0, '0, 1'b0, 1'b0, 1'b1);

    bad_req("badsrc14", 4'd14, 17'h00005);
    bad_req("badsrc15", 4'd15, 17'h00001);
    bad_req("baddst0", 4'd2, 17'h00000);

    // Asynchronous reset while in LOAD
    req_valid = 1'b1; req_src = 4'd3; req_dst = 17'h00005;
    step(); req_valid = 1'b0;
    step(); step();
    chk("rst_mid.pre_ld", 32'(ld), 32'h5);
    #2 rst_n = 1'b0;
    #1;
    chk_out("rst_mid.async", '0, '0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("rst_mid.after", '0, '0, 1'b0, 1'b0, 1'b1);
    end

    // Contention during SELECT (ext_drive high in cycle 2)
    req_valid = 1'b1; req_src = 4'd3; req_dst = 17'h00005;
    step(); req_valid = 1'b0;
    step(); ext_drive = 1'b1;
    chk_out("cont.c2", 14'h0008, '0, 1'b0, 1'b0, 1'b0);
    step(); ext_drive = 1'b0;
`ifdef BUS_XFER_CONTENTION_CHK_EN
    chk_out("cont.c3", '0, '0, 1'b0, 1'b1, 1'b0);
    step(); chk_out("cont.c4", '0, '0, 1'b0, 1'b0, 1'b1);
`else
    chk_out("cont.c3", 14'h0008, 17'h00005, 1'b0, 1'b0, 1'b0);
    step(); chk_out("cont.c4", '0, '0, 1'b1, 1'b0, 1'b0);
    step(); chk_out("cont.c5", '0, '0, 1'b0, 1'b0, 1'b1);
`endif

    // ext_drive high at acceptance
    ext_drive = 1'b1;
`ifdef BUS_XFER_CONTENTION_CHK_EN
    bad_req("cont_acc", 4'd1, 17'h00002);
    ext_drive = 1'b0;
`else
    xfer("cont_acc", 4'd1, 17'h00002, 14'h0002);
    ext_drive = 1'b0;
`endif

    step();
    chk("invariants", 32'(inv_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
